nios2_system_dataout_hs: RTL and testbench

Avalon-MM slave output port that sends bytes written by the Nios II CPU to the external wireless transmitter interface. It is the transmit-side counterpart of the 8-bit data-in PIO. Bytes are buffered in a small FIFO. Each byte is presented on out_port with a four-phase valid/ack handshake. Status and a sent-byte counter are readable over the same slave.

---
 rtl/nios2_system_dataout_hs.sv | 177 +++++++++++++++++
 tb/tb_nios2_system_dataout_hs.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/nios2_system_dataout_hs.sv
// ---------------------------------------------------------------------------
// nios2_system_dataout_hs
//
// Avalon-MM slave transmit port for the wireless transmitter. The CPU writes
// bytes into a small FIFO. A three-state handshake engine presents each byte
// on out_port with a four-phase valid/ack exchange. FIFO status and a running
// count of transmitted bytes can be read back over the same slave.
//
// Parameters
//   DEPTH      FIFO entries (power of two, 2..16)
//   CNT_W      width of the sent-byte counter
//
// Ports
//   clk        system clock
//   reset_n    synchronous active-low reset
//   address    register select (0 data, 1 status, 2 sent counter, 3 unused)
//   chipselect slave select
//   write_n    active-low write strobe, qualified by chipselect
//   writedata  write data
//   readdata   registered read data, one-cycle latency
//   out_port   byte presented to the transmitter
//   out_valid  out_port holds a valid byte
//   out_ack    transmitter acknowledge, already synchronous to clk
// ---------------------------------------------------------------------------
module nios2_system_dataout_hs #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  out_port,
    output logic        out_valid,
    input  logic        out_ack
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_RELEASE
    } state_t;

    state_t           r_state;
    logic [7:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic [CNT_W-1:0] r_sent;

    logic             w_wr;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_pushOk;
    logic             w_ovfSet;
    logic             w_ovfClr;
    logic             w_sentInc;
    logic             w_sentClr;
    logic             w_idle;
    logic [4:0]       w_countExt;
    logic [31:0]      w_readMux;

    assign w_wr      = chipselect & ~write_n;
    assign w_push    = w_wr && (address == 2'd0);
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    // A pop can only start from IDLE with data present, so it never coincides
    // with a push into an empty FIFO.
    assign w_pop     = (r_state == S_IDLE) && !w_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_pushOk  = w_push && (!w_full || w_pop);
    assign w_ovfSet  = w_push && w_full && !w_pop;
    assign w_ovfClr  = w_wr && (address == 2'd1) && writedata[2];
    assign w_sentInc = (r_state == S_ASSERT) && out_ack;
    assign w_sentClr = w_wr && (address == 2'd2);
    assign w_idle    = w_empty && (r_state == S_IDLE);
    assign w_countExt = 5'(r_count);

    // Read mux has no side effects; it is sampled into readdata every cycle.
    always_comb begin
        w_readMux = 32'd0;
        case (address)
            2'd0: w_readMux = {24'd0, out_port};
            2'd1: w_readMux = {24'd0, w_countExt, r_overflow, w_full, w_idle};
            2'd2: w_readMux = 32'(r_sent);
            default: w_readMux = 32'd0;
        endcase
    end

    // FIFO storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (w_pushOk) begin
            r_mem[r_wrPtr] <= writedata[7:0];
        end
    end

    // FIFO bookkeeping, status, sent counter, read register and the
    // valid/ack handshake engine.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_sent     <= '0;
            readdata   <= 32'd0;
            out_port   <= 8'd0;
            out_valid  <= 1'b0;
        end else begin
            readdata <= w_readMux;

            if (w_pushOk) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_pushOk, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase

            // Setting beats clearing so an overflow is never lost.
            if (w_ovfSet) begin
                r_overflow <= 1'b1;
            end else if (w_ovfClr) begin
                r_overflow <= 1'b0;
            end

            // Clearing beats counting; the counter wraps naturally.
            if (w_sentClr) begin
                r_sent <= '0;
            end else if (w_sentInc) begin
                r_sent <= r_sent + CNT_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    out_valid <= 1'b0;
                    if (w_pop) begin
                        out_port  <= r_mem[r_rdPtr];
                        out_valid <= 1'b1;
                        r_state   <= S_ASSERT;
                    end
                end
                S_ASSERT: begin
                    if (out_ack) begin
                        out_valid <= 1'b0;
                        r_state   <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    out_valid <= 1'b0;
                    // Ack held high stalls the next byte until it drops.
                    if (!out_ack) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios2_system_dataout_hs.sv
// ---------------------------------------------------------------------------
// tb_nios2_system_dataout_hs
//
// Directed bench for nios2_system_dataout_hs (DEPTH=4, CNT_W=4 so the sent
// counter wraps after 16 bytes). Inputs change on the falling edge and
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_nios2_system_dataout_hs;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        out_valid;
    logic        out_ack;

    int totalChecks = 0;
    int badChecks   = 0;

    nios2_system_dataout_hs #(
        .DEPTH(4),
        .CNT_W(4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .out_valid (out_valid),
        .out_ack   (out_ack)
    );

    // 10 ns system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports failures.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        assert (observed === expected) else begin
            badChecks++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One-cycle slave write, called and returning on a falling edge.
    task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Registered read: returns the register value as it stood at call time.
    task automatic readReg(input logic [1:0] a, output logic [31:0] d);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    // Bounded wait for out_valid; a timeout is reported as a failed check.
    task automatic waitValid(input string tag);
        for (int k = 0; k < 12 && out_valid !== 1'b1; k++) @(negedge clk);
        checkOutput(tag, {31'd0, out_valid}, 32'd1);
    endtask

    // Wait for a byte, check it, then acknowledge it for one cycle.
    task automatic sendOne(input string tag, input logic [7:0] expected);
        waitValid({tag, "_valid"});
        checkOutput({tag, "_byte"}, {24'd0, out_port}, {24'd0, expected});
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        sawValid;

        $display("[TB] start");
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        out_ack    = 1'b0;

        // 1. Reset state.
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_readdata", readdata, 32'd0);
        checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_port", {24'd0, out_port}, 32'd0);
        reset_n = 1'b1;
        readReg(2'd1, rd);
        checkOutput("rst_status", rd, 32'h0000_0001);

        // 2. Single byte with a delayed acknowledge.
        applyStimulus(2'd0, 32'h0000_00A5);
        checkOutput("single_valid_early", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        checkOutput("single_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("single_port", {24'd0, out_port}, 32'h0000_00A5);
        @(negedge clk);
        checkOutput("single_hold1", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        checkOutput("single_hold2", {31'd0, out_valid}, 32'd1);
        out_ack = 1'b1;
        @(negedge clk);
        checkOutput("single_drop", {31'd0, out_valid}, 32'd0);
        checkOutput("single_port_kept", {24'd0, out_port}, 32'h0000_00A5);
        out_ack = 1'b0;
        @(negedge clk);
        readReg(2'd1, rd);
        checkOutput("single_idle", rd, 32'h0000_0001);
        readReg(2'd2, rd);
        checkOutput("single_sent", rd, 32'd1);
        readReg(2'd0, rd);
        checkOutput("single_rd_port", rd, 32'h0000_00A5);

        // 3. Ack high while idle is ignored, then fill the FIFO to overflow.
        out_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        readReg(2'd1, rd);
        checkOutput("ack_idle_ignored", rd, 32'h0000_0001);
        for (int i = 1; i <= 6; i++) applyStimulus(2'd0, 32'(i));
        checkOutput("fill_port_first", {24'd0, out_port}, 32'h0000_0001);
        readReg(2'd1, rd);
        checkOutput("fill_status", rd, 32'h0000_0026);
        readReg(2'd2, rd);
        checkOutput("fill_sent", rd, 32'd2);
        applyStimulus(2'd1, 32'h0000_0004);
        readReg(2'd1, rd);
        checkOutput("ovf_cleared", rd, 32'h0000_0022);

        // 4. Push into a full FIFO on the cycle the head is popped.
        out_ack = 1'b0;
        @(negedge clk);
        applyStimulus(2'd0, 32'h0000_0006);
        checkOutput("poppush_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("poppush_port", {24'd0, out_port}, 32'h0000_0002);
        readReg(2'd1, rd);
        checkOutput("poppush_status", rd, 32'h0000_0022);
        for (int i = 2; i <= 6; i++) sendOne("drain", 8'(i));
        @(negedge clk);
        readReg(2'd1, rd);
        checkOutput("drain_idle", rd, 32'h0000_0001);
        readReg(2'd2, rd);
        checkOutput("drain_sent", rd, 32'd7);

        // 5. Counter clear, wrap, and clear coincident with an ack.
        applyStimulus(2'd2, 32'd0);
        readReg(2'd2, rd);
        checkOutput("cnt_clear", rd, 32'd0);
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(2'd0, 32'(i + 8'h40));
            sendOne("wrap", 8'(i + 8'h40));
        end
        readReg(2'd2, rd);
        checkOutput("cnt_15", rd, 32'd15);
        applyStimulus(2'd0, 32'h0000_0050);
        sendOne("wrap_last", 8'h50);
        readReg(2'd2, rd);
        checkOutput("cnt_wrap", rd, 32'd0);
        applyStimulus(2'd0, 32'h0000_0077);
        waitValid("coinc_valid");
        out_ack = 1'b1;
        applyStimulus(2'd2, 32'd0);
        out_ack = 1'b0;
        readReg(2'd2, rd);
        checkOutput("cnt_clear_wins", rd, 32'd0);
        readReg(2'd3, rd);
        checkOutput("addr3_zero", rd, 32'd0);
        @(negedge clk);

        // 6. Reset in the middle of a handshake with bytes queued.
        for (int i = 0; i < 4; i++) applyStimulus(2'd0, 32'(8'h11 * (i + 1)));
        checkOutput("mid_valid", {31'd0, out_valid}, 32'd1);
        readReg(2'd1, rd);
        checkOutput("mid_status", rd, 32'h0000_0018);
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_port", {24'd0, out_port}, 32'd0);
        reset_n = 1'b1;
        sawValid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            out_ack = k[0];
            @(negedge clk);
            sawValid = sawValid | out_valid;
        end
        out_ack = 1'b0;
        checkOutput("mid_no_more", {31'd0, sawValid}, 32'd0);
        readReg(2'd1, rd);
        checkOutput("mid_status_after", rd, 32'h0000_0001);
        readReg(2'd2, rd);
        checkOutput("mid_sent_after", rd, 32'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
